// File: rtl/mux8_32.sv
// Byte-to-word packer: gathers NB consecutive valid bytes MSB-first into one lane word
// and holds each word on lane_0 with valid_0 high for exactly NB clk_4f cycles.
module mux8_32 #(
  parameter int unsigned BW = 8,
  parameter int unsigned NB = 4
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [BW-1:0]    data_in,
  input  logic             valid_in,
  output logic [BW*NB-1:0] lane_0,
  output logic             valid_0,
  output logic             drop_err
);

  localparam int unsigned LW = BW * NB;
  localparam int unsigned CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [LW-BW-1:0] accum_q, accum_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            valid_q, valid_d;
  logic            drop_q, drop_d;
  logic            complete;
  logic [LW-1:0]   word;

  // The last byte never lands in accum; it goes straight into the word.
  assign complete = valid_in && (in_cnt_q == LAST);
  assign word     = {accum_q, data_in};

  always_comb begin
    in_cnt_d = in_cnt_q;
    accum_d  = accum_q;
    drop_d   = 1'b0;
    if (valid_in) begin
      if (in_cnt_q != LAST) begin
        for (int unsigned i = 0; i < NB - 1; i++) begin
          if (in_cnt_q == CW'(i)) accum_d[BW*(NB-2-i) +: BW] = data_in;
        end
        in_cnt_d = in_cnt_q + 1'b1;
      end else begin
        in_cnt_d = '0;
        accum_d  = '0;
      end
    end else if (in_cnt_q != '0) begin
      in_cnt_d = '0;
      accum_d  = '0;
      drop_d   = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;
    lane_d    = lane_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (complete) begin
          lane_d    = word;
          valid_d   = 1'b1;
          out_cnt_d = '0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_cnt_q == LAST) begin
          // A completion on the final hold cycle reloads with no gap in valid_0.
          if (complete) begin
            lane_d    = word;
            out_cnt_d = '0;
          end else begin
            valid_d   = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      accum_q   <= '0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      accum_q   <= accum_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign lane_0   = lane_q;
  assign valid_0  = valid_q;
  assign drop_err = drop_q;

  a_no_overrun: assert property (@(posedge clk_4f) disable iff (!reset)
    !(complete && state_q == HOLD && out_cnt_q != LAST));

endmodule

// File: tb/tb_mux8_32.sv
// Directed bench for mux8_32: vector table plus reset, mid-operation reset and long-stream sequences.
module tb_mux8_32;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] lane_0;
  logic        valid_0;
  logic        drop_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vin;
    logic [7:0]  din;
    logic        ev;
    logic [31:0] el;
    logic        ed;
  } vec_t;

  vec_t vecs[$];

  mux8_32 #(.BW(8), .NB(4)) dut (
    .clk_4f  (clk_4f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .lane_0  (lane_0),
    .valid_0 (valid_0),
    .drop_err(drop_err)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic void add(input logic vin, input logic [7:0] din,
                              input logic ev, input logic [31:0] el, input logic ed);
    vec_t v;
    v.vin = vin; v.din = din; v.ev = ev; v.el = el; v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic vin, input logic [7:0] din);
    @(negedge clk_4f);
    valid_in = vin;
    data_in  = din;
    @(posedge clk_4f);
    #1;
  endtask

  logic [7:0] stream[256];

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 8'($urandom));
      chk("rst_lane", lane_0, 32'h0);
      chk("rst_valid", {31'b0, valid_0}, 32'h0);
      chk("rst_drop", {31'b0, drop_err}, 32'h0);
    end
    @(negedge clk_4f);
    valid_in = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h5A);
      chk("post_rst_lane", lane_0, 32'h0);
      chk("post_rst_valid", {31'b0, valid_0}, 32'h0);
      chk("post_rst_drop", {31'b0, drop_err}, 32'h0);
    end

    // Single word
    add(1, 8'hAA, 0, 32'h0, 0);
    add(1, 8'hBB, 0, 32'h0, 0);
    add(1, 8'hCC, 0, 32'h0, 0);
    add(1, 8'hDD, 1, 32'hAABBCCDD, 0);
    add(0, 8'h00, 1, 32'hAABBCCDD, 0);
    add(0, 8'h00, 1, 32'hAABBCCDD, 0);
    add(0, 8'h00, 1, 32'hAABBCCDD, 0);
    add(0, 8'h00, 0, 32'hAABBCCDD, 0);
    add(0, 8'h00, 0, 32'hAABBCCDD, 0);
    // Back-to-back 01..0C
    add(1, 8'h01, 0, 32'hAABBCCDD, 0);
    add(1, 8'h02, 0, 32'hAABBCCDD, 0);
    add(1, 8'h03, 0, 32'hAABBCCDD, 0);
    add(1, 8'h04, 1, 32'h01020304, 0);
    add(1, 8'h05, 1, 32'h01020304, 0);
    add(1, 8'h06, 1, 32'h01020304, 0);
    add(1, 8'h07, 1, 32'h01020304, 0);
    add(1, 8'h08, 1, 32'h05060708, 0);
    add(1, 8'h09, 1, 32'h05060708, 0);
    add(1, 8'h0A, 1, 32'h05060708, 0);
    add(1, 8'h0B, 1, 32'h05060708, 0);
    add(1, 8'h0C, 1, 32'h090A0B0C, 0);
    add(0, 8'h00, 1, 32'h090A0B0C, 0);
    add(0, 8'h00, 1, 32'h090A0B0C, 0);
    add(0, 8'h00, 1, 32'h090A0B0C, 0);
    add(0, 8'h00, 0, 32'h090A0B0C, 0);
    // Partial drop after 2 bytes, then a clean word
    add(1, 8'h11, 0, 32'h090A0B0C, 0);
    add(1, 8'h22, 0, 32'h090A0B0C, 0);
    add(0, 8'h00, 0, 32'h090A0B0C, 1);
    add(0, 8'h00, 0, 32'h090A0B0C, 0);
    add(1, 8'h01, 0, 32'h090A0B0C, 0);
    add(1, 8'h02, 0, 32'h090A0B0C, 0);
    add(1, 8'h03, 0, 32'h090A0B0C, 0);
    add(1, 8'h04, 1, 32'h01020304, 0);
    add(0, 8'h00, 1, 32'h01020304, 0);
    add(0, 8'h00, 1, 32'h01020304, 0);
    add(0, 8'h00, 1, 32'h01020304, 0);
    add(0, 8'h00, 0, 32'h01020304, 0);
    // Drop at the last slot boundary (3 bytes)
    add(1, 8'h31, 0, 32'h01020304, 0);
    add(1, 8'h32, 0, 32'h01020304, 0);
    add(1, 8'h33, 0, 32'h01020304, 0);
    add(0, 8'h00, 0, 32'h01020304, 1);
    // Drop during HOLD leaves valid_0 untouched
    add(1, 8'hB1, 0, 32'h01020304, 0);
    add(1, 8'hB2, 0, 32'h01020304, 0);
    add(1, 8'hB3, 0, 32'h01020304, 0);
    add(1, 8'hB4, 1, 32'hB1B2B3B4, 0);
    add(1, 8'hC1, 1, 32'hB1B2B3B4, 0);
    add(0, 8'h00, 1, 32'hB1B2B3B4, 1);
    add(0, 8'h00, 1, 32'hB1B2B3B4, 0);
    add(0, 8'h00, 0, 32'hB1B2B3B4, 0);

    foreach (vecs[i]) begin
      step(vecs[i].vin, vecs[i].din);
      chk($sformatf("vec%0d_lane", i), lane_0, vecs[i].el);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_0}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d_drop", i), {31'b0, drop_err}, {31'b0, vecs[i].ed});
    end

    // Reset mid-operation: word 1 in HOLD, 2 bytes of word 2 accumulated
    step(1, 8'h10); step(1, 8'h20); step(1, 8'h30); step(1, 8'h40);
    chk("mid_w1_lane", lane_0, 32'h10203040);
    step(1, 8'h50); step(1, 8'h60);
    chk("mid_w1_valid", {31'b0, valid_0}, 32'h1);
    @(negedge clk_4f);
    valid_in = 1'b0;
    reset    = 1'b0;
    #1;
    chk("mid_async_valid", {31'b0, valid_0}, 32'h0);
    chk("mid_async_lane", lane_0, 32'h0);
    chk("mid_async_drop", {31'b0, drop_err}, 32'h0);
    @(negedge clk_4f);
    reset = 1'b1;
    step(0, 8'h00);
    chk("mid_rel_drop", {31'b0, drop_err}, 32'h0);
    chk("mid_rel_valid", {31'b0, valid_0}, 32'h0);
    step(1, 8'hA1); step(1, 8'hA2); step(1, 8'hA3);
    chk("mid_pre_valid", {31'b0, valid_0}, 32'h0);
    step(1, 8'hA4);
    chk("mid_w_lane", lane_0, 32'hA1A2A3A4);
    chk("mid_w_valid", {31'b0, valid_0}, 32'h1);
    for (int i = 0; i < 4; i++) step(0, 8'h00);
    chk("mid_end_valid", {31'b0, valid_0}, 32'h0);

    // Long continuous stream: every held word must match the bytes fed in
    for (int i = 0; i < 256; i++) stream[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      step(1, stream[i]);
      if (i >= 3) begin
        int k;
        k = (i + 1) / 4 - 1;
        chk($sformatf("loop%0d_valid", i), {31'b0, valid_0}, 32'h1);
        chk($sformatf("loop%0d_lane", i), lane_0,
            {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]});
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00);
      chk("loop_tail_valid", {31'b0, valid_0}, 32'h1);
    end
    step(0, 8'h00);
    chk("loop_end_valid", {31'b0, valid_0}, 32'h0);
    chk("loop_end_lane", lane_0, {stream[252], stream[253], stream[254], stream[255]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
